// File: rtl/mw93_eeprom_ctrl.sv
// Microwire (93xx, x16) EEPROM command sequencer with a single request/response handshake.
// Optional build macro EE_DUMMY_CHECK_EN: flag a READ whose dummy-0 bit was sampled as 1.
module mw93_eeprom_ctrl #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned BUSY_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do,
  output logic              busy
);

  localparam int unsigned FrameW  = 3 + ADDR_W + DATA_W;
  localparam int unsigned CmdBits = 3 + ADDR_W;
  localparam int unsigned BitW    = $clog2(FrameW + 1);
  localparam int unsigned DivW    = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned PollW   = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [BitW-1:0]  CmdLast   = BitW'(CmdBits - 1);
  localparam logic [BitW-1:0]  FrameLast = BitW'(FrameW - 1);
  localparam logic [DivW-1:0]  DivLast   = DivW'(2 * CLK_DIV - 1);
  localparam logic [DivW-1:0]  SkHigh    = DivW'(CLK_DIV);
  localparam logic [PollW-1:0] PollLast  = PollW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StShift = 3'd1;
  localparam logic [2:0] StRdata = 3'd2;
  localparam logic [2:0] StCslow = 3'd3;
  localparam logic [2:0] StPoll  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [2:0] OpRead  = 3'd0;
  localparam logic [2:0] OpWrite = 3'd1;
  localparam logic [2:0] OpErase = 3'd2;
  localparam logic [2:0] OpEwen  = 3'd3;
  localparam logic [2:0] OpEwds  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [FrameW-1:0] frame_q, frame_d, frame_v;
  logic [BitW-1:0]   last_q, last_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic              cs_q, cs_d;
  logic              di_q, di_d;
  logic [DATA_W-1:0] shin_q, shin_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              op_ok;
  logic              read_err;
`ifdef EE_DUMMY_CHECK_EN
  logic              dummy_q, dummy_d;
  assign read_err = dummy_q;
`else
  assign read_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    frame_d = frame_q;
    last_d  = last_q;
    bit_d   = bit_q;
    div_d   = div_q;
    poll_d  = poll_q;
    cs_d    = cs_q;
    di_d    = di_q;
    shin_d  = shin_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    frame_v = '0;
    op_ok   = 1'b1;
`ifdef EE_DUMMY_CHECK_EN
    dummy_d = dummy_q;
`endif
    unique case (state_q)
      StIdle: begin
        last_d = CmdLast;
        case (req_op)
          OpRead:  begin
            frame_v = {3'b110, req_addr, {DATA_W{1'b0}}};
            last_d  = FrameLast;
          end
          OpWrite: begin
            frame_v = {3'b101, req_addr, req_wdata};
            last_d  = FrameLast;
          end
          OpErase: frame_v = {3'b111, req_addr, {DATA_W{1'b0}}};
          OpEwen:  frame_v = {3'b100, 2'b11, {(ADDR_W - 2){1'b0}}, {DATA_W{1'b0}}};
          OpEwds:  frame_v = {3'b100, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
          default: op_ok = 1'b0;
        endcase
        if (req_valid) begin
          op_d  = req_op;
          bit_d = '0;
          div_d = '0;
          if (op_ok) begin
            // First bit goes out immediately; the rest shift from frame_q.
            state_d = StShift;
            cs_d    = 1'b1;
            di_d    = frame_v[FrameW-1];
            frame_d = frame_v << 1;
            shin_d  = '0;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      StShift, StRdata: begin
        div_d = div_q + 1'b1;
        if (div_q == DivLast) begin
          div_d = '0;
`ifdef EE_DUMMY_CHECK_EN
          if (bit_q == CmdLast) dummy_d = ee_do;
`endif
          if (state_q == StRdata) shin_d = {shin_q[DATA_W-2:0], ee_do};
          if (bit_q == last_q) begin
            cs_d = 1'b0;
            di_d = 1'b0;
            if (op_q == OpWrite || op_q == OpErase) begin
              state_d = StCslow;
            end else begin
              state_d = StDone;
              rdata_d = (op_q == OpRead) ? {shin_q[DATA_W-2:0], ee_do} : '0;
              err_d   = (op_q == OpRead) ? read_err : 1'b0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            di_d    = frame_q[FrameW-1];
            frame_d = frame_q << 1;
            if (bit_q == CmdLast && op_q == OpRead) state_d = StRdata;
          end
        end
      end
      StCslow: begin
        div_d = div_q + 1'b1;
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StPoll;
          cs_d    = 1'b1;
          poll_d  = '0;
        end
      end
      StPoll: begin
        if (ee_do || poll_q == PollLast) begin
          state_d = StDone;
          cs_d    = 1'b0;
          err_d   = ~ee_do;
          rdata_d = '0;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      frame_q <= '0;
      last_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      poll_q  <= '0;
      cs_q    <= 1'b0;
      di_q    <= 1'b0;
      shin_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef EE_DUMMY_CHECK_EN
      dummy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      poll_q  <= poll_d;
      cs_q    <= cs_d;
      di_q    <= di_d;
      shin_q  <= shin_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef EE_DUMMY_CHECK_EN
      dummy_q <= dummy_d;
`endif
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign ee_cs     = cs_q;
  assign ee_di     = di_q;
  assign ee_sk     = (state_q == StShift || state_q == StRdata) && (div_q >= SkHigh);
  assign rsp_valid = (state_q == StDone);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mw93_eeprom_ctrl.sv
// Bench for mw93_eeprom_ctrl: a word-level EEPROM model answers frames, and every
// transaction's bit stream, timing and response are checked against spec arithmetic.
module tb_mw93_eeprom_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        ee_cs;
  logic        ee_sk;
  logic        ee_di;
  logic        ee_do;
  logic        busy;

  mw93_eeprom_ctrl #(
    .ADDR_W      (6),
    .DATA_W      (16),
    .CLK_DIV     (4),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ee_cs    (ee_cs),
    .ee_sk    (ee_sk),
    .ee_di    (ee_di),
    .ee_do    (ee_do),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int compares = 0;
  int mism = 0;

  logic [15:0] mem [64];
  bit          wen = 1'b0;

  int          rsp_cyc, cs_first, cs_fall, cs_rise, n_bits, di_bad, rr_bad, busy_bad;
  logic [31:0] bitsv;
  logic [15:0] rsp_data;
  logic        rsp_e, cs_at_rsp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp)
    else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("rst_cs", ee_cs, 0);
    chk("rst_sk", ee_sk, 0);
    chk("rst_di", ee_di, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
  endtask

  // Drives one request and plays the EEPROM side cycle by cycle until the response.
  task automatic run_cmd(input logic [2:0] op, input logic [5:0] addr, input logic [15:0] wd,
                         input int bsy, input bit stuck, input bit dmy, input bit hold,
                         input int abort_at);
    logic        prev_sk, prev_di;
    logic [15:0] word;
    int          ready_at, idx;
    rsp_cyc = -1; cs_first = -1; cs_fall = -1; cs_rise = -1; n_bits = 0;
    di_bad = 0; rr_bad = 0; busy_bad = 0; bitsv = '0; rsp_data = '0; rsp_e = 1'b0;
    cs_at_rsp = 1'b0; prev_sk = 1'b0; prev_di = 1'b0; ready_at = -1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (abort_at > 0 && cyc == abort_at + 1) begin
        chk_idle();
        rst = 1'b0;
        break;
      end
      if (abort_at > 0 && cyc == abort_at) rst = 1'b1;
      if (req_ready) rr_bad++;
      if (!busy) busy_bad++;
      if (ee_cs && cs_first < 0) cs_first = cyc;
      if (!ee_cs && cs_first >= 0 && cs_fall < 0) cs_fall = cyc;
      if (ee_cs && cs_fall >= 0 && cs_rise < 0) cs_rise = cyc;
      if (!ee_cs && ee_di) di_bad++;
      if (ee_sk && ee_di !== prev_di) di_bad++;
      if (ee_cs && ee_sk && !prev_sk) begin
        bitsv = {bitsv[30:0], ee_di};
        n_bits++;
        if (op == 3'd0 && n_bits == 9) ee_do = dmy;
        if (op == 3'd0 && n_bits >= 10 && n_bits <= 25) begin
          word  = mem[addr];
          idx   = 25 - n_bits;
          ee_do = word[idx];
        end
      end
      if ((op == 3'd1 || op == 3'd2) && cs_fall >= 0 && ready_at < 0) ready_at = cs_fall + bsy;
      if ((op == 3'd1 || op == 3'd2) && cs_rise >= 0) ee_do = !stuck && cyc >= ready_at;
      prev_sk = ee_sk;
      prev_di = ee_di;
      if (rsp_valid) begin
        rsp_cyc = cyc; rsp_data = rsp_rdata; rsp_e = rsp_err; cs_at_rsp = ee_cs;
        break;
      end
    end
    ee_do = 1'b0;
    if (abort_at == 0) chk("rsp_seen", rsp_cyc > 0, 1);
  endtask

  task automatic txn(input logic [2:0] op, input logic [5:0] addr, input logic [15:0] wd,
                     input int bsy, input bit stuck, input bit dmy, input bit hold);
    int          nb, fall, rise, ersp;
    logic [8:0]  ecmd;
    logic [15:0] edata;
    bit          eerr, prog;
    prog = (op == 3'd1 || op == 3'd2);
    nb   = (op == 3'd0 || op == 3'd1) ? 25 : 9;
    case (op)
      3'd0:    ecmd = {3'b110, addr};
      3'd1:    ecmd = {3'b101, addr};
      3'd2:    ecmd = {3'b111, addr};
      3'd3:    ecmd = {3'b100, 6'b110000};
      default: ecmd = {3'b100, 6'b000000};
    endcase
    edata = (op == 3'd0) ? mem[addr] : 16'h0;
    eerr  = stuck;
`ifdef EE_DUMMY_CHECK_EN
    if (op == 3'd0 && dmy) eerr = 1'b1;
`endif
    fall = nb * 8 + 1;
    rise = fall + 8;
    if (!prog) ersp = fall;
    else if (stuck) ersp = rise + TO;
    else ersp = ((rise > fall + bsy) ? rise : fall + bsy) + 1;
    run_cmd(op, addr, wd, bsy, stuck, dmy, hold, 0);
    chk("frame_bits", n_bits, nb);
    chk("cmd_field", bitsv >> (nb - 9), {23'h0, ecmd});
    if (op == 3'd1) chk("wdata_field", bitsv[15:0], wd);
    chk("cs_first", cs_first, 1);
    chk("cs_fall", cs_fall, fall);
    if (prog) chk("cs_rise", cs_rise, rise);
    chk("rsp_cycle", rsp_cyc, ersp);
    chk("rsp_rdata", rsp_data, edata);
    chk("rsp_err", rsp_e, eerr);
    chk("cs_at_rsp", cs_at_rsp, 0);
    chk("di_rules", di_bad, 0);
    chk("ready_low", rr_bad, 0);
    chk("busy_high", busy_bad, 0);
    if (op == 3'd3) wen = 1'b1;
    if (op == 3'd4) wen = 1'b0;
    if (op == 3'd1 && !stuck && wen) mem[addr] = wd;
    if (op == 3'd2 && !stuck && wen) mem[addr] = 16'hFFFF;
  endtask

  initial begin
    int vcount;
    logic [5:0] a;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; ee_do = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hA55A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle();
    rst = 1'b0;

    txn(3'd3, 6'h00, 16'h0, 0, 0, 0, 0);                  // EWEN
    txn(3'd0, 6'h05, 16'h0, 0, 0, 0, 0);                  // READ 0xA55A
    txn(3'd1, 6'h3F, 16'h1234, 50, 0, 0, 0);              // WRITE, busy 50
    txn(3'd0, 6'h3F, 16'h0, 0, 0, 0, 0);
    txn(3'd2, 6'h11, 16'h0, 0, 1, 0, 0);                  // ERASE, ee_do stuck 0
    txn(3'd0, 6'h07, 16'h0, 0, 0, 0, 1);                  // request held during READ
    txn(3'd0, 6'h07, 16'h0, 0, 0, 0, 0);

    run_cmd(3'd6, 6'h00, 16'h0, 0, 0, 0, 0, 0);           // invalid op
    chk("inv_rsp_cycle", rsp_cyc, 1);
    chk("inv_err", rsp_e, 1);
    chk("inv_rdata", rsp_data, 0);
    chk("inv_no_cs", cs_first, -1);

    txn(3'd0, 6'h05, 16'h0, 0, 0, 1, 0);                  // dummy bit read as 1

    for (int k = 0; k < 8; k++) begin
      a = 6'($urandom);
      if ($urandom_range(1, 0) == 1) txn(3'd1, a, 16'($urandom), $urandom_range(50, 1), 0, 0, 0);
      txn(3'd0, a, 16'h0, 0, 0, 0, 0);
    end

    txn(3'd4, 6'h00, 16'h0, 0, 0, 0, 0);                  // EWDS
    txn(3'd1, 6'h05, 16'hBEEF, 5, 0, 0, 0);
    txn(3'd0, 6'h05, 16'h0, 0, 0, 0, 0);
    txn(3'd3, 6'h00, 16'h0, 0, 0, 0, 0);
    txn(3'd2, 6'h05, 16'h0, 3, 0, 0, 0);
    txn(3'd0, 6'h05, 16'h0, 0, 0, 0, 0);

    run_cmd(3'd1, 6'h2A, 16'h5678, 10, 0, 0, 0, 40);      // reset during WRITE
    chk("abort_no_rsp", rsp_cyc, -1);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || ee_cs) vcount++;
    end
    chk("abort_quiet", vcount, 0);
    txn(3'd0, 6'h2A, 16'h0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
